pipe_hazard_unit: RTL and testbench
===================================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter RADDR_W, 5, register-address width.
REQ-002 SHALL have parameter STAGES, 3, tracked stages after ID (1=EX … STAGES=WB), legal 2..6.
REQ-003 SHALL have parameter LOAD_STAGE, 2, first stage at which load data is forwardable, legal 1..STAGES.
REQ-004 SHALL have parameter CNT_W, 32, performance-counter width.
REQ-005 clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 id_valid  in  1  ID holds a real instruction.
REQ-007 id_rs, id_rt  in  RADDR_W each  ID source registers.
REQ-008 id_rs_used, id_rt_used  in  1 each  source actually read.
REQ-009 id_wr_en  in  1  ID instruction writes a register; id_wr_reg  in  RADDR_W  its destination.
REQ-010 id_is_load  in  1  ID instruction is a load.
REQ-011 id_redirect  in  1  ID resolved a taken branch/jump.
REQ-012 cnt_clr  in  1  synchronous counter clear.
REQ-013 stall  out  1  hold PC and IF/ID, bubble into EX.
REQ-014 flush_if_id  out  1  squash the fetched instruction.
REQ-015 fwd_rs_sel, fwd_rt_sel  out  FW=clog2(STAGES+1) each  0=register file, k=stage k result.
REQ-016 stall_cnt, flush_cnt  out  CNT_W each  event counters.

Function
REQ-017 SHALL keep a scoreboard entry per stage k: v, we, rd, ld.
REQ-018 Entry k SHALL match source r when v & we & rd==r & r!=0 and the source is used; r=0 SHALL never match.
REQ-019 For each source, the youngest (smallest k) match SHALL decide; no match -> sel 0.
REQ-020 Youngest match SHALL be forwardable if ld==0 or k>=LOAD_STAGE; then sel=k.
REQ-021 Youngest match not forwardable SHALL assert stall (combinational, same cycle) with sel 0.
REQ-022 stall SHALL be gated by id_valid.
REQ-023 Every cycle s[k+1]<=s[k]; the oldest entry SHALL retire.
REQ-024 Without stall, s[1] SHALL load {id_valid & ~flush_if_id_q, id_wr_en, id_wr_reg, id_is_load}.
REQ-025 With stall, s[1] SHALL load an invalid bubble.
REQ-026 flush_if_id SHALL equal id_redirect & ~stall (stall wins; the branch re-evaluates next cycle).
REQ-027 flush_if_id_q (registered flush_if_id) SHALL invalidate the instruction entering s[1] on the following cycle.
REQ-028 stall_cnt SHALL increment on each stall cycle, flush_cnt on each flush_if_id cycle, both saturating at all-ones.
REQ-029 cnt_clr SHALL zero both counters, taking priority over increment.

Reset
REQ-030 rst_n low SHALL clear all scoreboard v bits, flush_if_id_q and both counters immediately.
REQ-031 During and after reset, with id_valid=0: stall=0, flush_if_id=0, both sels=0, counters=0.
REQ-032 Reset asserted mid-stall SHALL drop stall; the first post-reset cycle sees an empty scoreboard.

Structure
REQ-033 Shared package pipe_pkg SHALL hold the scoreboard-entry struct, FW derivation and FWD_REGFILE=0 constant.
REQ-034 One sub-module hazard_lookup (one source vs. scoreboard -> match/sel/need_stall) SHALL be instantiated twice.

Verification (STAGES=3, LOAD_STAGE=2)
REQ-035 add r3 enters EX, next ID reads rs=r3 -> fwd_rs_sel=1, stall=0.
REQ-036 lw r4 in EX, ID reads rt=r4 -> stall=1 for exactly one cycle, then fwd_rt_sel=2, stall_cnt=1.
REQ-037 s[1] and s[3] both write r5, ID reads r5 on rs and rt -> both sels=1.
REQ-038 Write to r0 in EX, ID reads r0 -> sel=0, stall=0.
REQ-039 id_redirect with no hazard -> flush_if_id=1 one cycle, flush_cnt=1, next s[1].v=0; with load-use stall -> flush_if_id=0.
REQ-040 rst_n low during stall -> stall=0 within reset, counters 0; cnt_clr with a concurrent stall -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard unit
// Scoreboard entry, forward-select width derivation and the register-file select code.
package pipe_pkg;

  // Widest register address an entry can hold; narrower addresses are zero-extended.
  localparam int RD_MAX_W    = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                v;
    logic                we;
    logic [RD_MAX_W-1:0] rd;
    logic                ld;
  } sb_entry_t;

  function automatic int fw_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/hazard_lookup.sv
// rtl/hazard_lookup.sv - one source register checked against the stage scoreboard
// The youngest matching stage decides: forward from it, or stall if its load data is not ready yet.
module hazard_lookup
  import pipe_pkg::*;
#(
  parameter  int RADDR_W    = 5,
  parameter  int STAGES     = 3,
  parameter  int LOAD_STAGE = 2,
  localparam int FW         = fw_width(STAGES)
) (
  input  logic [RADDR_W-1:0]   i_src,
  input  logic                 i_used,
  input  sb_entry_t [STAGES:1] i_sb,
  output logic                 o_match,
  output logic [FW-1:0]        o_sel,
  output logic                 o_need_stall
);

  logic [RD_MAX_W-1:0] w_src;

  assign w_src = RD_MAX_W'(i_src);

  // Scan oldest to youngest so the youngest hit is the last one to assign.
  always_comb begin
    o_match      = 1'b0;
    o_sel        = FW'(FWD_REGFILE);
    o_need_stall = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (i_used && (w_src != '0) && i_sb[k].v && i_sb[k].we && (i_sb[k].rd == w_src)) begin
        o_match = 1'b1;
        if (!i_sb[k].ld || (k >= LOAD_STAGE)) begin
          o_sel        = FW'(k);
          o_need_stall = 1'b0;
        end else begin
          o_sel        = FW'(FWD_REGFILE);
          o_need_stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - scoreboard-based forwarding, load-use stall and branch flush control
// Tracks the writers in EX..WB, steers operand forwarding and counts stall/flush events.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter  int RADDR_W    = 5,
  parameter  int STAGES     = 3,
  parameter  int LOAD_STAGE = 2,
  parameter  int CNT_W      = 32,
  localparam int FW         = fw_width(STAGES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_id_valid,
  input  logic [RADDR_W-1:0] i_id_rs,
  input  logic [RADDR_W-1:0] i_id_rt,
  input  logic               i_id_rs_used,
  input  logic               i_id_rt_used,
  input  logic               i_id_wr_en,
  input  logic [RADDR_W-1:0] i_id_wr_reg,
  input  logic               i_id_is_load,
  input  logic               i_id_redirect,
  input  logic               i_cnt_clr,
  output logic               o_stall,
  output logic               o_flush_if_id,
  output logic [FW-1:0]      o_fwd_rs_sel,
  output logic [FW-1:0]      o_fwd_rt_sel,
  output logic [CNT_W-1:0]   o_stall_cnt,
  output logic [CNT_W-1:0]   o_flush_cnt
);

  sb_entry_t [STAGES:1] r_sb;
  logic                 r_flush_q;
  logic [CNT_W-1:0]     r_stall_cnt;
  logic [CNT_W-1:0]     r_flush_cnt;

  logic      w_rs_match, w_rs_need;
  logic      w_rt_match, w_rt_need;
  logic      w_stall;
  logic      w_flush;
  sb_entry_t w_s1_next;

  hazard_lookup #(
    .RADDR_W    (RADDR_W),
    .STAGES     (STAGES),
    .LOAD_STAGE (LOAD_STAGE)
  ) u_rs_lookup (
    .i_src        (i_id_rs),
    .i_used       (i_id_rs_used),
    .i_sb         (r_sb),
    .o_match      (w_rs_match),
    .o_sel        (o_fwd_rs_sel),
    .o_need_stall (w_rs_need)
  );

  hazard_lookup #(
    .RADDR_W    (RADDR_W),
    .STAGES     (STAGES),
    .LOAD_STAGE (LOAD_STAGE)
  ) u_rt_lookup (
    .i_src        (i_id_rt),
    .i_used       (i_id_rt_used),
    .i_sb         (r_sb),
    .o_match      (w_rt_match),
    .o_sel        (o_fwd_rt_sel),
    .o_need_stall (w_rt_need)
  );

  assign w_stall = i_id_valid & ((w_rs_match & w_rs_need) | (w_rt_match & w_rt_need));
  // A stalled branch is re-evaluated next cycle, so it must not flush yet.
  assign w_flush = i_id_redirect & ~w_stall;

  always_comb begin
    w_s1_next = '0;
    if (!w_stall) begin
      w_s1_next.v  = i_id_valid & ~r_flush_q;
      w_s1_next.we = i_id_wr_en;
      w_s1_next.rd = RD_MAX_W'(i_id_wr_reg);
      w_s1_next.ld = i_id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb      <= '0;
      r_flush_q <= 1'b0;
    end else begin
      r_sb      <= {r_sb[STAGES-1:1], w_s1_next};
      r_flush_q <= w_flush;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall       = w_stall;
  assign o_flush_if_id = w_flush;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - directed and random checks of pipe_hazard_unit against a reference model
module tb_pipe_hazard_unit;

  localparam int RADDR_W    = 5;
  localparam int STAGES     = 3;
  localparam int LOAD_STAGE = 2;
  localparam int CNT_W      = 4;
  localparam int FW         = 2;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, id_redirect, cnt_clr;
  logic [RADDR_W-1:0] id_rs, id_rt, id_wr_reg;
  logic               stall, flush_if_id;
  logic [FW-1:0]      fwd_rs_sel, fwd_rt_sel;
  logic [CNT_W-1:0]   stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: one record per pipeline stage, 1 = EX.
  bit m_v [1:STAGES];
  bit m_we[1:STAGES];
  int m_rd[1:STAGES];
  bit m_ld[1:STAGES];
  bit m_fq;
  int m_sc, m_fc;
  bit e_stall, e_flush;

  always #5 clk = ~clk;

  pipe_hazard_unit #(
    .RADDR_W    (RADDR_W),
    .STAGES     (STAGES),
    .LOAD_STAGE (LOAD_STAGE),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_id_valid    (id_valid),
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .i_id_rs_used  (id_rs_used),
    .i_id_rt_used  (id_rt_used),
    .i_id_wr_en    (id_wr_en),
    .i_id_wr_reg   (id_wr_reg),
    .i_id_is_load  (id_is_load),
    .i_id_redirect (id_redirect),
    .i_cnt_clr     (cnt_clr),
    .o_stall       (stall),
    .o_flush_if_id (flush_if_id),
    .o_fwd_rs_sel  (fwd_rs_sel),
    .o_fwd_rt_sel  (fwd_rt_sel),
    .o_stall_cnt   (stall_cnt),
    .o_flush_cnt   (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int k = 1; k <= STAGES; k++) begin
      m_v[k] = 0; m_we[k] = 0; m_rd[k] = 0; m_ld[k] = 0;
    end
    m_fq = 0; m_sc = 0; m_fc = 0;
  endtask

  // Nearest producer wins; a load not yet at LOAD_STAGE forces a stall.
  function automatic void exp_src(input int r, input bit used, output int sel, output bit stl);
    sel = 0;
    stl = 0;
    if (!used || r == 0) return;
    for (int k = 1; k <= STAGES; k++) begin
      if (m_v[k] && m_we[k] && m_rd[k] == r) begin
        if (!m_ld[k] || k >= LOAD_STAGE) sel = k;
        else stl = 1;
        return;
      end
    end
  endfunction

  task automatic set_in(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                        input bit we, input int wr, input bit ld, input bit redir, input bit clr);
    id_valid = v; id_rs = RADDR_W'(rs); id_rs_used = rsu; id_rt = RADDR_W'(rt); id_rt_used = rtu;
    id_wr_en = we; id_wr_reg = RADDR_W'(wr); id_is_load = ld; id_redirect = redir; cnt_clr = clr;
  endtask

  task automatic settle();
    int  s_rs, s_rt;
    bit  t_rs, t_rt;
    @(negedge clk);
    exp_src(int'(id_rs), id_rs_used, s_rs, t_rs);
    exp_src(int'(id_rt), id_rt_used, s_rt, t_rt);
    e_stall = id_valid && (t_rs || t_rt);
    e_flush = id_redirect && !e_stall;
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush_if_id", 32'(flush_if_id), 32'(e_flush));
    chk("fwd_rs_sel", 32'(fwd_rs_sel), 32'(s_rs));
    chk("fwd_rt_sel", 32'(fwd_rt_sel), 32'(s_rt));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_sc));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_fc));
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst_n) begin
      for (int k = STAGES; k >= 2; k--) begin
        m_v[k] = m_v[k-1]; m_we[k] = m_we[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
      end
      m_v[1]  = !e_stall && id_valid && !m_fq;
      m_we[1] = id_wr_en;
      m_rd[1] = int'(id_wr_reg);
      m_ld[1] = id_is_load;
      m_fq    = e_flush;
      if (cnt_clr) begin
        m_sc = 0; m_fc = 0;
      end else begin
        if (e_stall && m_sc < CNT_MAX) m_sc++;
        if (e_flush && m_fc < CNT_MAX) m_fc++;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      adv();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mreset();
    settle();
    adv();
    settle();
    adv();
    rst_n = 1'b1;
    idle(1);

    // ALU result in EX forwards to the next instruction
    set_in(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); settle(); adv();
    set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("alu_fwd_sel", 32'(fwd_rs_sel), 1);
    chk("alu_fwd_stall", 32'(stall), 0);
    adv(); idle(3);

    // Load-use: one stall cycle, then forward from stage 2
    set_in(1, 0, 0, 0, 0, 1, 4, 1, 0, 0); settle(); adv();
    set_in(1, 0, 0, 4, 1, 0, 0, 0, 0, 0); settle();
    chk("lduse_stall", 32'(stall), 1);
    adv(); settle();
    chk("lduse_after_stall", 32'(stall), 0);
    chk("lduse_rt_sel", 32'(fwd_rt_sel), 2);
    chk("lduse_stall_cnt", 32'(stall_cnt), 1);
    adv(); idle(3);

    // Two producers of r5: the younger one wins for both sources
    set_in(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); settle(); adv();
    set_in(1, 0, 0, 0, 0, 1, 6, 0, 0, 0); settle(); adv();
    set_in(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); settle(); adv();
    set_in(1, 5, 1, 5, 1, 0, 0, 0, 0, 0); settle();
    chk("youngest_rs", 32'(fwd_rs_sel), 1);
    chk("youngest_rt", 32'(fwd_rt_sel), 1);
    adv(); idle(3);

    // r0 never matches
    set_in(1, 0, 0, 0, 0, 1, 0, 1, 0, 0); settle(); adv();
    set_in(1, 0, 1, 0, 1, 0, 0, 0, 0, 0); settle();
    chk("r0_rs_sel", 32'(fwd_rs_sel), 0);
    chk("r0_stall", 32'(stall), 0);
    adv(); idle(3);

    // Redirect without hazard flushes once; the squashed instruction never becomes a producer
    set_in(1, 0, 0, 0, 0, 1, 9, 0, 1, 0); settle();
    chk("redir_flush", 32'(flush_if_id), 1);
    adv();
    set_in(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); settle();
    chk("redir_flush_once", 32'(flush_if_id), 0);
    chk("redir_flush_cnt", 32'(flush_cnt), 1);
    adv();
    set_in(1, 7, 1, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("squashed_not_fwd", 32'(fwd_rs_sel), 0);
    adv(); idle(3);

    // Redirect during a load-use stall is held back
    set_in(1, 0, 0, 0, 0, 1, 4, 1, 0, 0); settle(); adv();
    set_in(1, 4, 1, 0, 0, 0, 0, 0, 1, 0); settle();
    chk("redir_stall", 32'(stall), 1);
    chk("redir_stall_flush", 32'(flush_if_id), 0);
    adv(); settle(); adv(); idle(3);

    // Random traffic with small register numbers to provoke hazards and counter saturation
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 3) != 0,
             int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 39) == 0);
      settle();
      adv();
    end
    idle(3);

    // Asynchronous reset during a stall
    set_in(1, 0, 0, 0, 0, 1, 4, 1, 0, 0); settle(); adv();
    set_in(1, 0, 0, 4, 1, 0, 0, 0, 0, 0); settle();
    chk("prerst_stall", 32'(stall), 1);
    rst_n = 1'b0;
    #1;
    mreset();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    adv(); settle(); adv();
    rst_n = 1'b1;
    settle();
    chk("postrst_stall", 32'(stall), 0);
    adv(); idle(3);

    // Clear wins over a concurrent stall increment
    set_in(1, 0, 0, 0, 0, 1, 4, 1, 0, 0); settle(); adv();
    set_in(1, 0, 0, 4, 1, 0, 0, 0, 0, 0); settle(); adv(); settle(); adv();
    set_in(1, 0, 0, 0, 0, 1, 4, 1, 0, 0); settle(); adv();
    set_in(1, 0, 0, 4, 1, 0, 0, 0, 0, 1); settle();
    chk("clr_stall", 32'(stall), 1);
    adv();
    set_in(1, 0, 0, 4, 1, 0, 0, 0, 0, 0); settle();
    chk("clr_stall_cnt", 32'(stall_cnt), 0);
    adv(); idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
